// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: opcodes, the bubble
// word, instruction field positions and the fetch-stage state encoding.
package pipe_pkg;

  // Opcodes carried in the top three bits of an instruction.
  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_BEQ   = 3'd2;
  localparam logic [2:0] OP_6     = 3'd6;

  // R-type writing r0: architecturally a no-op, used as the pipeline bubble.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Instruction field positions.
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam int RS_MSB = 12;
  localparam int RS_LSB = 10;
  localparam int RT_MSB = 9;
  localparam int RT_LSB = 7;
  localparam int RD_MSB = 6;
  localparam int RD_LSB = 4;

  // Fetch-stage control states.
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  // Extract the opcode field of an instruction word.
  function automatic logic [2:0] get_opcode(input logic [15:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for board-debug performance statistics. Sticks at
// all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  // Count accepted events, holding once the all-ones ceiling is reached.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID pipeline register. Follows the hazard
// controller's pc_stall/mp requests, inserts a one-cycle bubble on a
// redirect, and keeps saturating stall/flush counters for debug.
module fetch_stage #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(pipe_pkg::NOP_INSTR),
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pc_stall,
  input  logic                   mp,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc1,
  output logic                   ifid_valid,
  output logic                   idex_flush,
  output logic [CNT_WIDTH-1:0]   stall_count,
  output logic [CNT_WIDTH-1:0]   flush_count
);

  import pipe_pkg::*;

  fetch_state_e           state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    pc_plus1_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q;
  logic [PC_WIDTH-1:0]    ifid_pc1_q;
  logic                   ifid_valid_q;
  logic                   idex_flush_q;
  logic                   stall_inc_d;
  logic                   flush_inc_d;

  // Decode which requests are accepted this cycle: BOOT ignores both, and
  // REDIRECT ignores mp so a lingering mp level cannot redirect twice.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pc_plus1_d  = pc_q + PC_WIDTH'(1);
    stall_inc_d = 1'b0;
    flush_inc_d = 1'b0;
    case (state_q)
      RUN: begin
        flush_inc_d = mp;
        stall_inc_d = pc_stall && !mp;
      end
      REDIRECT: stall_inc_d = pc_stall;
      default: ;
    endcase
  end

  // Fetch FSM: PC, IF/ID register and the registered ID/EX flush pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc1_q   <= '0;
      ifid_valid_q <= 1'b0;
      idex_flush_q <= 1'b0;
    end else begin
      idex_flush_q <= 1'b0;
      case (state_q)
        BOOT: begin
          ifid_instr_q <= imem_data;
          ifid_pc1_q   <= pc_plus1_d;
          ifid_valid_q <= 1'b1;
          pc_q         <= pc_plus1_d;
          state_q      <= RUN;
        end
        RUN: begin
          if (mp) begin
            pc_q         <= branch_target;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            idex_flush_q <= 1'b1;
            state_q      <= REDIRECT;
          end else if (!pc_stall) begin
            ifid_instr_q <= imem_data;
            ifid_pc1_q   <= pc_plus1_d;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_plus1_d;
          end
        end
        REDIRECT: begin
          if (!pc_stall) begin
            ifid_instr_q <= imem_data;
            ifid_pc1_q   <= pc_plus1_d;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_plus1_d;
          end
          state_q <= RUN;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc_d),
    .count (stall_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc_d),
    .count (flush_count)
  );

  assign imem_addr  = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc1   = ifid_pc1_q;
  assign ifid_valid = ifid_valid_q;
  assign idex_flush = idex_flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a table of per-cycle vectors drives a full-width DUT
// and a 2-bit-counter DUT side by side; expectations travel through a
// scoreboard queue and are compared one edge later.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pc_stall = 1'b0;
  logic        mp = 1'b0;
  logic [15:0] branch_target = '0;

  logic [15:0] imem_addr, imem_data, ifid_instr, ifid_pc1;
  logic        ifid_valid, idex_flush;
  logic [15:0] stall_count, flush_count;

  logic [15:0] imem_addr_s, imem_data_s, ifid_instr_s, ifid_pc1_s;
  logic        ifid_valid_s, idex_flush_s;
  logic [1:0]  stall_count_s, flush_count_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        stall;
    logic        mp;
    logic [15:0] bt;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        valid;
    logic        flush;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[20];

  always #5 clock = ~clock;

  // Instruction memory contents known to the bench.
  function automatic logic [15:0] imem_fn(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h2484;
      16'h0001: return 16'h4401;
      default:  return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5};
    endcase
  endfunction

  assign imem_data   = imem_fn(imem_addr);
  assign imem_data_s = imem_fn(imem_addr_s);

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .pc_stall      (pc_stall),
    .mp            (mp),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_instr    (ifid_instr),
    .ifid_pc1      (ifid_pc1),
    .ifid_valid    (ifid_valid),
    .idex_flush    (idex_flush),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  fetch_stage #(.CNT_WIDTH(2)) dut_sat (
    .clock         (clock),
    .reset         (reset),
    .pc_stall      (pc_stall),
    .mp            (mp),
    .branch_target (branch_target),
    .imem_addr     (imem_addr_s),
    .imem_data     (imem_data_s),
    .ifid_instr    (ifid_instr_s),
    .ifid_pc1      (ifid_pc1_s),
    .ifid_valid    (ifid_valid_s),
    .idex_flush    (idex_flush_s),
    .stall_count   (stall_count_s),
    .flush_count   (flush_count_s)
  );

  function automatic vec_t mk(input logic stall, input logic mpv, input logic [15:0] bt,
                              input logic [15:0] pc, input logic [15:0] instr,
                              input logic [15:0] pc1, input logic valid, input logic flush,
                              input logic [15:0] sc, input logic [15:0] fc);
    vec_t v;
    v.stall = stall; v.mp = mpv; v.bt = bt; v.pc = pc; v.instr = instr;
    v.pc1 = pc1; v.valid = valid; v.flush = flush; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  function automatic logic [31:0] sat2(input logic [15:0] x);
    return (x > 16'd3) ? 32'd3 : {16'd0, x};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " pc"},       {16'd0, imem_addr},  32'd0);
    check({tag, " instr"},    {16'd0, ifid_instr}, 32'd0);
    check({tag, " pc1"},      {16'd0, ifid_pc1},   32'd0);
    check({tag, " valid"},    {31'd0, ifid_valid}, 32'd0);
    check({tag, " flush"},    {31'd0, idex_flush}, 32'd0);
    check({tag, " stall_ct"}, {16'd0, stall_count}, 32'd0);
    check({tag, " flush_ct"}, {16'd0, flush_count}, 32'd0);
    check({tag, " sat pc"},   {16'd0, imem_addr_s}, 32'd0);
    check({tag, " sat cnts"}, {28'd0, stall_count_s, flush_count_s}, 32'd0);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare just after the edge.
  task automatic drive_and_check(input int id, input vec_t v);
    vec_t e;
    string t;
    pc_stall      = v.stall;
    mp            = v.mp;
    branch_target = v.bt;
    sb_q.push_back(v);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    t = $sformatf("step%0d", id);
    check({t, " pc"},       {16'd0, imem_addr},   {16'd0, e.pc});
    check({t, " instr"},    {16'd0, ifid_instr},  {16'd0, e.instr});
    check({t, " pc1"},      {16'd0, ifid_pc1},    {16'd0, e.pc1});
    check({t, " valid"},    {31'd0, ifid_valid},  {31'd0, e.valid});
    check({t, " flush"},    {31'd0, idex_flush},  {31'd0, e.flush});
    check({t, " stall_ct"}, {16'd0, stall_count}, {16'd0, e.sc});
    check({t, " flush_ct"}, {16'd0, flush_count}, {16'd0, e.fc});
    check({t, " sat pc"},       {16'd0, imem_addr_s},   {16'd0, e.pc});
    check({t, " sat instr"},    {16'd0, ifid_instr_s},  {16'd0, e.instr});
    check({t, " sat pc1"},      {16'd0, ifid_pc1_s},    {16'd0, e.pc1});
    check({t, " sat vf"},       {30'd0, ifid_valid_s, idex_flush_s}, {30'd0, e.valid, e.flush});
    check({t, " sat stall_ct"}, {30'd0, stall_count_s}, sat2(e.sc));
    check({t, " sat flush_ct"}, {30'd0, flush_count_s}, sat2(e.fc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    //            stall mp  bt        pc        instr                 pc1       v     f     sc     fc
    tbl[0]  = mk(1'b0, 1'b0, 16'h0000, 16'h0001, 16'h2484,            16'h0001, 1'b1, 1'b0, 16'd0, 16'd0);
    tbl[1]  = mk(1'b0, 1'b0, 16'h0000, 16'h0002, 16'h4401,            16'h0002, 1'b1, 1'b0, 16'd0, 16'd0);
    tbl[2]  = mk(1'b0, 1'b0, 16'h0000, 16'h0003, imem_fn(16'h0002),   16'h0003, 1'b1, 1'b0, 16'd0, 16'd0);
    tbl[3]  = mk(1'b0, 1'b0, 16'h0000, 16'h0004, imem_fn(16'h0003),   16'h0004, 1'b1, 1'b0, 16'd0, 16'd0);
    tbl[4]  = mk(1'b0, 1'b0, 16'h0000, 16'h0005, imem_fn(16'h0004),   16'h0005, 1'b1, 1'b0, 16'd0, 16'd0);
    tbl[5]  = mk(1'b1, 1'b0, 16'h0000, 16'h0005, imem_fn(16'h0004),   16'h0005, 1'b1, 1'b0, 16'd1, 16'd0);
    tbl[6]  = mk(1'b1, 1'b0, 16'h0000, 16'h0005, imem_fn(16'h0004),   16'h0005, 1'b1, 1'b0, 16'd2, 16'd0);
    tbl[7]  = mk(1'b1, 1'b0, 16'h0000, 16'h0005, imem_fn(16'h0004),   16'h0005, 1'b1, 1'b0, 16'd3, 16'd0);
    tbl[8]  = mk(1'b0, 1'b0, 16'h0000, 16'h0006, imem_fn(16'h0005),   16'h0006, 1'b1, 1'b0, 16'd3, 16'd0);
    tbl[9]  = mk(1'b0, 1'b0, 16'h0000, 16'h0007, imem_fn(16'h0006),   16'h0007, 1'b1, 1'b0, 16'd3, 16'd0);
    tbl[10] = mk(1'b0, 1'b1, 16'h0040, 16'h0040, 16'h0000,            16'h0007, 1'b0, 1'b1, 16'd3, 16'd1);
    tbl[11] = mk(1'b0, 1'b0, 16'h0000, 16'h0041, imem_fn(16'h0040),   16'h0041, 1'b1, 1'b0, 16'd3, 16'd1);
    tbl[12] = mk(1'b1, 1'b1, 16'h0080, 16'h0080, 16'h0000,            16'h0041, 1'b0, 1'b1, 16'd3, 16'd2);
    tbl[13] = mk(1'b0, 1'b1, 16'h0123, 16'h0081, imem_fn(16'h0080),   16'h0081, 1'b1, 1'b0, 16'd3, 16'd2);
    tbl[14] = mk(1'b0, 1'b1, 16'h0200, 16'h0200, 16'h0000,            16'h0081, 1'b0, 1'b1, 16'd3, 16'd3);
    tbl[15] = mk(1'b1, 1'b0, 16'h0000, 16'h0200, 16'h0000,            16'h0081, 1'b0, 1'b0, 16'd4, 16'd3);
    tbl[16] = mk(1'b0, 1'b0, 16'h0000, 16'h0201, imem_fn(16'h0200),   16'h0201, 1'b1, 1'b0, 16'd4, 16'd3);
    tbl[17] = mk(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000,            16'h0201, 1'b0, 1'b1, 16'd4, 16'd4);
    tbl[18] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, imem_fn(16'hFFFF),   16'h0000, 1'b1, 1'b0, 16'd4, 16'd4);
    tbl[19] = mk(1'b0, 1'b0, 16'h0000, 16'h0001, 16'h2484,            16'h0001, 1'b1, 1'b0, 16'd4, 16'd4);

    // Power-on reset, checked while reset is still held.
    #2 reset = 1'b0;
    #10;
    check_reset("reset");

    // Release and run the vector table; the first edge is the BOOT fetch.
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clock);
      drive_and_check(i, tbl[i]);
    end

    // Redirect, then reset asynchronously while in REDIRECT.
    @(negedge clock);
    drive_and_check(20, mk(1'b0, 1'b1, 16'h0030, 16'h0030, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'd4, 16'd5));
    #2 reset = 1'b0;
    #1;
    check_reset("mid_redirect_reset");

    // BOOT must fetch address 0 even with pc_stall high, without counting a stall.
    @(negedge clock);
    reset = 1'b1;
    drive_and_check(21, mk(1'b1, 1'b0, 16'h0000, 16'h0001, 16'h2484, 16'h0001, 1'b1, 1'b0, 16'd0, 16'd0));
    @(negedge clock);
    drive_and_check(22, mk(1'b1, 1'b0, 16'h0000, 16'h0001, 16'h2484, 16'h0001, 1'b1, 1'b0, 16'd1, 16'd0));
    @(negedge clock);
    drive_and_check(23, mk(1'b0, 1'b0, 16'h0000, 16'h0002, 16'h4401, 16'h0002, 1'b1, 1'b0, 16'd1, 16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
